pc_branch_unit: RTL and testbench
=================================

// Module: pc_branch_unit
// PURPOSE
//  Program-counter stage downstream of the 8->32 sign extender. Consumes the extended branch/jump offset
//  and computes target = PC + 4 + (offset << 2). Holds the PC register and selects sequential or redirected
//  fetch. On a taken redirect, marks the following instruction slot(s) invalid (FLUSH). Honours memory BUSYWAIT stalls.
// PARAMETERS
//  RESET_PC      32'h0000_0000  PC value loaded on reset
//  FLUSH_CYCLES  1              cycles FLUSH is held after a taken redirect (1..15)
//  CNT_W         16             width of saturating taken-redirect counter
// PORTS
//  CLK          in   1      rising-edge clock
//  RESET        in   1      asynchronous, active-high reset
//  OFFSET_EXT   in   32     sign-extended word offset from sign extender
//  JUMP         in   1      unconditional jump for current instruction
//  BRANCH       in   1      beq for current instruction
//  ZERO         in   1      ALU zero flag (beq condition)
//  BUSYWAIT     in   1      memory stall; 1 = hold all state
//  PC           out  32     current fetch address (registered)
//  PC_PLUS4     out  32     PC + 4 (combinational from PC register)
//  FLUSH        out  1      1 = instruction in current slot must be squashed (registered)
//  TAKEN_CNT    out  CNT_W  count of taken redirects, saturating (registered)
// BEHAVIOUR
//  - Reset: async, active-high. PC=RESET_PC, FLUSH=0, TAKEN_CNT=0, state=RUN, flush counter=0.
//    Reset asserted mid-flush or mid-stall aborts everything immediately; no pending redirect survives.
//  - Arithmetic: all 32-bit modulo 2^32. target = PC + 32'd4 + {OFFSET_EXT[29:0],2'b00}. Negative offsets
//    wrap naturally. No overflow flag. PC+4 at 32'hFFFF_FFFC wraps to 0.
//  - take = JUMP | (BRANCH & ZERO), valid only in state RUN with BUSYWAIT=0.
//  - States: RUN, FLUSH.
//    RUN, BUSYWAIT=1: hold PC, state, counters; controls ignored.
//    RUN, BUSYWAIT=0, take=0: PC <= PC+4.
//    RUN, BUSYWAIT=0, take=1: PC <= target; FLUSH <= 1; flush counter <= FLUSH_CYCLES-1; TAKEN_CNT++ (saturate
//      at all-ones); state -> FLUSH.
//    FLUSH, BUSYWAIT=1: hold everything, FLUSH stays 1.
//    FLUSH, BUSYWAIT=0: PC <= PC+4; JUMP/BRANCH ignored (squashed slot).
//      Counter == 0 -> FLUSH <= 0, state -> RUN; else counter decrements.
//  - Latency: a redirect is visible on PC one edge after the resolving edge. FLUSH rises on the same edge and
//    stays high for exactly FLUSH_CYCLES non-stalled cycles.
//  - JUMP and BRANCH both high: treated as a jump (take=1 regardless of ZERO).
//  - X/Z on controls while BUSYWAIT=1 must not alter state.
//  - All state updates are on posedge CLK, except reset. No # delays inside the RTL.
// TESTING
//  1 Reset: RESET=1 mid-run -> PC=0, FLUSH=0, TAKEN_CNT=0 immediately, before the next CLK edge.
//  2 Sequential: no controls, 3 edges from PC=0 -> PC=4,8,12. PC_PLUS4 tracks PC+4.
//  3 Forward beq: PC=8, BRANCH=1, ZERO=1, OFFSET_EXT=2 -> PC=20, FLUSH=1 one cycle, TAKEN_CNT=1.
//    Same with ZERO=0 -> PC=12, FLUSH=0.
//  4 Backward jump: PC=16, JUMP=1, OFFSET_EXT=32'hFFFF_FFFB (-5) -> PC=0. The next-cycle JUMP=1 is ignored
//    because FLUSH is set -> PC=4.
//  5 Stall: BUSYWAIT=1 for 3 edges during both RUN and FLUSH -> PC, FLUSH, TAKEN_CNT frozen; resumes on release.
//    With FLUSH_CYCLES=3, FLUSH stays high for 3 unstalled cycles.
//  6 Wrap and saturate: PC=32'hFFFF_FFFC, no control -> PC=0. CNT_W=2 with 5 taken jumps -> TAKEN_CNT=3.

Source files
------------

// File: rtl/pc_branch_unit.sv
`default_nettype none
// ============================================================================
// Module      : pc_branch_unit
// Description : PC register with branch/jump redirect, post-redirect flush
//               window, memory stall hold and saturating taken counter.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_branch_unit #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          FLUSH_CYCLES = 1,
  parameter int          CNT_W        = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [31:0]      OFFSET_EXT,
  input  logic             JUMP,
  input  logic             BRANCH,
  input  logic             ZERO,
  input  logic             BUSYWAIT,
  output logic [31:0]      PC,
  output logic [31:0]      PC_PLUS4,
  output logic             FLUSH,
  output logic [CNT_W-1:0] TAKEN_CNT
);

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  localparam logic [3:0] c_FLUSH_INIT = 4'(FLUSH_CYCLES - 1);

  state_t            state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic [3:0]        fcnt_q, fcnt_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              flush_q, flush_d;

  logic [31:0]       w_pc_plus4;
  logic [31:0]       w_target;
  logic              w_take;

  assign w_pc_plus4 = pc_q + 32'd4;
  assign w_target   = w_pc_plus4 + {OFFSET_EXT[29:0], 2'b00};
  // Jump dominates: with JUMP high the ZERO flag is irrelevant.
  assign w_take     = JUMP | (BRANCH & ZERO);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    fcnt_d  = fcnt_q;
    cnt_d   = cnt_q;
    flush_d = flush_q;
    // Controls are only looked at when the stage is not stalled.
    if (!BUSYWAIT) begin
      case (state_q)
        ST_RUN: begin
          if (w_take) begin
            pc_d    = w_target;
            flush_d = 1'b1;
            fcnt_d  = c_FLUSH_INIT;
            state_d = ST_FLUSH;
            if (cnt_q != {CNT_W{1'b1}}) begin
              cnt_d = cnt_q + 1'b1;
            end
          end else begin
            pc_d = w_pc_plus4;
          end
        end
        ST_FLUSH: begin
          pc_d = w_pc_plus4;
          if (fcnt_q == 4'd0) begin
            flush_d = 1'b0;
            state_d = ST_RUN;
          end else begin
            fcnt_d = fcnt_q - 4'd1;
          end
        end
        default: begin
          flush_d = 1'b0;
          state_d = ST_RUN;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
      fcnt_q  <= 4'd0;
      cnt_q   <= '0;
      flush_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      fcnt_q  <= fcnt_d;
      cnt_q   <= cnt_d;
      flush_q <= flush_d;
    end
  end

  assign PC        = pc_q;
  assign PC_PLUS4  = w_pc_plus4;
  assign FLUSH     = flush_q;
  assign TAKEN_CNT = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_branch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_branch_unit
// Description : Directed self-checking bench for pc_branch_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_branch_unit;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;

  // dut0: default parameters
  logic [31:0] off0 = '0;
  logic        j0 = 1'b0, b0 = 1'b0, z0 = 1'b0, bw0 = 1'b0;
  logic [31:0] pc0, pcp0;
  logic        fl0;
  logic [15:0] cnt0;

  // dut1: three-cycle flush window
  logic [31:0] off1 = '0;
  logic        j1 = 1'b0, b1 = 1'b0, z1 = 1'b0, bw1 = 1'b1;
  logic [31:0] pc1, pcp1;
  logic        fl1;
  logic [15:0] cnt1;

  // dut2: 2-bit counter, reset PC near the top of the address space
  logic [31:0] off2 = '0;
  logic        j2 = 1'b0, b2 = 1'b0, z2 = 1'b0, bw2 = 1'b1;
  logic [31:0] pc2, pcp2;
  logic        fl2;
  logic [1:0]  cnt2;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  pc_branch_unit u_dut0 (
    .CLK(CLK), .RESET(RESET), .OFFSET_EXT(off0), .JUMP(j0), .BRANCH(b0), .ZERO(z0),
    .BUSYWAIT(bw0), .PC(pc0), .PC_PLUS4(pcp0), .FLUSH(fl0), .TAKEN_CNT(cnt0)
  );

  pc_branch_unit #(.FLUSH_CYCLES(3)) u_dut1 (
    .CLK(CLK), .RESET(RESET), .OFFSET_EXT(off1), .JUMP(j1), .BRANCH(b1), .ZERO(z1),
    .BUSYWAIT(bw1), .PC(pc1), .PC_PLUS4(pcp1), .FLUSH(fl1), .TAKEN_CNT(cnt1)
  );

  pc_branch_unit #(.RESET_PC(32'hFFFF_FFF8), .CNT_W(2)) u_dut2 (
    .CLK(CLK), .RESET(RESET), .OFFSET_EXT(off2), .JUMP(j2), .BRANCH(b2), .ZERO(z2),
    .BUSYWAIT(bw2), .PC(pc2), .PC_PLUS4(pcp2), .FLUSH(fl2), .TAKEN_CNT(cnt2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  initial begin
    // ---------------- reset state ----------------
    tick(2);
    RESET = 1'b0;
    chk("rst_pc0", pc0, 32'h0);
    chk("rst_fl0", {31'd0, fl0}, 32'h0);
    chk("rst_cnt0", {16'd0, cnt0}, 32'h0);
    chk("rst_pcp0", pcp0, 32'h4);

    // ---------------- sequential ----------------
    tick(); chk("seq_pc4", pc0, 32'h4);
    tick(); chk("seq_pc8", pc0, 32'h8);
    chk("seq_pcp12", pcp0, 32'hC);

    // ---------------- forward beq taken at PC=8 ----------------
    b0 = 1'b1; z0 = 1'b1; off0 = 32'd2;
    tick();
    chk("beq_pc", pc0, 32'd20);
    chk("beq_fl", {31'd0, fl0}, 32'h1);
    chk("beq_cnt", {16'd0, cnt0}, 32'd1);
    b0 = 1'b0; z0 = 1'b0;
    tick();
    chk("beq_after_pc", pc0, 32'd24);
    chk("beq_after_fl", {31'd0, fl0}, 32'h0);

    // ---------------- beq not taken ----------------
    b0 = 1'b1; z0 = 1'b0; off0 = 32'd2;
    tick();
    chk("bnt_pc", pc0, 32'd28);
    chk("bnt_fl", {31'd0, fl0}, 32'h0);
    chk("bnt_cnt", {16'd0, cnt0}, 32'd1);

    // ---------------- backward jump from 28 lands at 12 ----------------
    b0 = 1'b0; j0 = 1'b1; off0 = 32'hFFFF_FFFB;
    tick();
    chk("jb1_pc", pc0, 32'd12);
    chk("jb1_cnt", {16'd0, cnt0}, 32'd2);
    j0 = 1'b0;
    tick();
    chk("jb1_after_pc", pc0, 32'd16);

    // ---------------- backward jump from 16 to 0, next jump squashed ----------------
    j0 = 1'b1; off0 = 32'hFFFF_FFFB;
    tick();
    chk("jb2_pc", pc0, 32'd0);
    chk("jb2_fl", {31'd0, fl0}, 32'h1);
    tick();
    chk("squash_pc", pc0, 32'd4);
    chk("squash_fl", {31'd0, fl0}, 32'h0);
    chk("squash_cnt", {16'd0, cnt0}, 32'd3);

    // ---------------- JUMP and BRANCH together, ZERO=0 ----------------
    j0 = 1'b1; b0 = 1'b1; z0 = 1'b0; off0 = 32'd1;
    tick();
    chk("jb_both_pc", pc0, 32'd12);
    chk("jb_both_cnt", {16'd0, cnt0}, 32'd4);

    // ---------------- stall during FLUSH with unknown controls ----------------
    bw0 = 1'b1; j0 = 1'bx; b0 = 1'bx; z0 = 1'bx; off0 = 'x;
    tick(3);
    chk("stf_pc", pc0, 32'd12);
    chk("stf_fl", {31'd0, fl0}, 32'h1);
    chk("stf_cnt", {16'd0, cnt0}, 32'd4);
    bw0 = 1'b0; j0 = 1'b0; b0 = 1'b0; z0 = 1'b0; off0 = '0;
    tick();
    chk("stf_rel_pc", pc0, 32'd16);
    chk("stf_rel_fl", {31'd0, fl0}, 32'h0);

    // ---------------- stall during RUN with a pending jump ----------------
    bw0 = 1'b1; j0 = 1'b1; off0 = 32'd5;
    tick(3);
    chk("str_pc", pc0, 32'd16);
    chk("str_cnt", {16'd0, cnt0}, 32'd4);
    chk("str_fl", {31'd0, fl0}, 32'h0);
    bw0 = 1'b0; j0 = 1'b0;
    tick();
    chk("str_rel_pc", pc0, 32'd20);

    // ---------------- jump to top of address space, wrap in flush ----------------
    j0 = 1'b1; off0 = 32'hFFFF_FFF9;
    tick();
    chk("top_pc", pc0, 32'hFFFF_FFFC);
    chk("top_pcp", pcp0, 32'h0);
    j0 = 1'b0;
    tick();
    chk("wrap_pc", pc0, 32'h0);
    tick();
    chk("pre_rst_pc", pc0, 32'h4);

    // ---------------- asynchronous reset mid-run ----------------
    #2 RESET = 1'b1;
    #1;
    chk("arst_pc0", pc0, 32'h0);
    chk("arst_fl0", {31'd0, fl0}, 32'h0);
    chk("arst_cnt0", {16'd0, cnt0}, 32'h0);
    chk("arst_pc2", pc2, 32'hFFFF_FFF8);
    tick();
    RESET = 1'b0;
    bw0 = 1'b1;

    // ---------------- dut1: three-cycle flush window with stall ----------------
    bw1 = 1'b0; j1 = 1'b1; off1 = 32'd3;
    tick();
    chk("f3_pc_a", pc1, 32'd16);
    chk("f3_fl_a", {31'd0, fl1}, 32'h1);
    tick();
    chk("f3_pc_b", pc1, 32'd20);
    chk("f3_fl_b", {31'd0, fl1}, 32'h1);
    bw1 = 1'b1;
    tick(3);
    chk("f3_stall_pc", pc1, 32'd20);
    chk("f3_stall_fl", {31'd0, fl1}, 32'h1);
    bw1 = 1'b0;
    tick();
    chk("f3_pc_c", pc1, 32'd24);
    chk("f3_fl_c", {31'd0, fl1}, 32'h1);
    tick();
    chk("f3_pc_d", pc1, 32'd28);
    chk("f3_fl_d", {31'd0, fl1}, 32'h0);
    chk("f3_cnt_d", {16'd0, cnt1}, 32'd1);
    tick();
    chk("f3_retake_pc", pc1, 32'd44);
    chk("f3_retake_cnt", {16'd0, cnt1}, 32'd2);
    j1 = 1'b0; bw1 = 1'b1;

    // ---------------- dut2: sequential wrap and counter saturation ----------------
    bw2 = 1'b0;
    chk("w_pcp", pcp2, 32'hFFFF_FFFC);
    tick();
    chk("w_pc_top", pc2, 32'hFFFF_FFFC);
    chk("w_pcp_top", pcp2, 32'h0);
    tick();
    chk("w_pc_zero", pc2, 32'h0);
    j2 = 1'b1; off2 = 32'd0;
    tick(5);
    chk("sat_cnt_3", {30'd0, cnt2}, 32'd3);
    chk("sat_pc_mid", pc2, 32'd20);
    tick(5);
    chk("sat_cnt_5", {30'd0, cnt2}, 32'd3);
    chk("sat_pc", pc2, 32'd40);
    tick();
    chk("sat_fl", {31'd0, fl2}, 32'h1);
    chk("sat_pc2", pc2, 32'd44);

    // ---------------- asynchronous reset mid-flush ----------------
    j2 = 1'b0;
    #2 RESET = 1'b1;
    #1;
    chk("mf_rst_pc", pc2, 32'hFFFF_FFF8);
    chk("mf_rst_fl", {31'd0, fl2}, 32'h0);
    chk("mf_rst_cnt", {30'd0, cnt2}, 32'd0);
    tick();
    RESET = 1'b0;
    tick();
    chk("mf_post_pc", pc2, 32'hFFFF_FFFC);
    chk("mf_post_fl", {31'd0, fl2}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
